// File: rtl/snake_move_scheduler_if.sv
// Control and move handshake bundle shared by the navigation FSM, the move scheduler and the body updater.
// master = scheduler side (drives MOVE_REQ/HEAD/status), slave = environment side.
interface snake_move_scheduler_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           start;
    logic           stop;
    logic           pause;
    logic [1:0]     speed;
    logic [1:0]     dir_in;
    logic           move_ack;
    logic           move_req;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     dir_out;
    logic           running;
    logic           overrun;
    logic           hit_wall;

    modport master (
        input  start, stop, pause, speed, dir_in, move_ack,
        output move_req, head_x, head_y, dir_out, running, overrun, hit_wall
    );

    modport slave (
        output start, stop, pause, speed, dir_in, move_ack,
        input  move_req, head_x, head_y, dir_out, running, overrun, hit_wall
    );
endinterface

// File: rtl/snake_move_scheduler.sv
// Paces snake motion: tick counter, reversal filter, next-head computation and REQ/ACK hand-off.
// Optional macro WRAP_EN: head wraps at grid edges instead of raising HIT_WALL and stopping.
module snake_move_scheduler #(
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int BASE_PERIOD = 25_000_000,
    parameter int X_INIT      = 80,
    parameter int Y_INIT      = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    snake_move_scheduler_if.master bus
);
    localparam int PER_W = $clog2(BASE_PERIOD + 1);
    localparam logic [PER_W-1:0] BASE_VEC = PER_W'(BASE_PERIOD);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]   X_START  = X_W'(X_INIT);
    localparam logic [Y_W-1:0]   Y_START  = Y_W'(Y_INIT);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, REQ} state_t;

    state_t           state_reg, state_next;
    logic [PER_W-1:0] cnt_reg, cnt_next;
    logic [PER_W-1:0] period_reg, period_next;
    logic [1:0]       pending_dir_reg, pending_dir_next;
    logic [1:0]       dir_reg, dir_next;
    logic [X_W-1:0]   head_x_reg, head_x_next;
    logic [Y_W-1:0]   head_y_reg, head_y_next;
    logic             move_req_reg, move_req_next;
    logic             running_reg, running_next;
    logic             overrun_reg, overrun_next;
    logic             hit_wall_reg, hit_wall_next;
    logic             stop_pend_reg, stop_pend_next;

    logic             tick;
    logic             do_move;
    logic [PER_W-1:0] period_load;
    logic [X_W-1:0]   step_x;
    logic [Y_W-1:0]   step_y;
    logic             step_wall;

    assign period_load = BASE_VEC >> bus.speed;
    assign tick = (state_reg != IDLE) && !bus.pause && (cnt_reg == period_reg - 1'b1);

    // Candidate head for the pending direction; edges compared explicitly, never via width overflow.
    always_comb begin
        step_x    = head_x_reg;
        step_y    = head_y_reg;
        step_wall = 1'b0;
        case (pending_dir_reg)
            DIR_UP: begin
                if (head_y_reg == '0) begin
`ifdef WRAP_EN
                    step_y = Y_LAST;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_y = head_y_reg - 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (head_x_reg >= X_LAST) begin
`ifdef WRAP_EN
                    step_x = '0;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_x = head_x_reg + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (head_y_reg >= Y_LAST) begin
`ifdef WRAP_EN
                    step_y = '0;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_y = head_y_reg + 1'b1;
                end
            end
            default: begin
                if (head_x_reg == '0) begin
`ifdef WRAP_EN
                    step_x = X_LAST;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_x = head_x_reg - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        period_next      = period_reg;
        pending_dir_next = pending_dir_reg;
        dir_next         = dir_reg;
        head_x_next      = head_x_reg;
        head_y_next      = head_y_reg;
        move_req_next    = move_req_reg;
        overrun_next     = overrun_reg;
        hit_wall_next    = hit_wall_reg;
        stop_pend_next   = stop_pend_reg;
        do_move          = 1'b0;

        // A 180-degree turn would run the head into its own neck, so it is simply ignored.
        if (bus.dir_in != (dir_reg ^ 2'd2)) begin
            pending_dir_next = bus.dir_in;
        end

        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if (!bus.pause) begin
            if (tick) begin
                cnt_next    = '0;
                period_next = period_load;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (tick) begin
                    do_move = 1'b1;
                end
            end
            REQ: begin
                if (bus.stop) begin
                    stop_pend_next = 1'b1;
                end
                if (bus.move_ack) begin
                    move_req_next = 1'b0;
                    if (bus.stop || stop_pend_reg) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                    end else if (tick) begin
                        do_move = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end else if (tick) begin
                    overrun_next = 1'b1;
                end
            end
            default: ;
        endcase

        if (do_move) begin
            dir_next = pending_dir_reg;
            if (step_wall) begin
                hit_wall_next = 1'b1;
                move_req_next = 1'b0;
                state_next    = IDLE;
            end else begin
                head_x_next   = step_x;
                head_y_next   = step_y;
                move_req_next = 1'b1;
                state_next    = REQ;
            end
        end

        if (bus.start) begin
            state_next       = RUN;
            cnt_next         = '0;
            period_next      = period_load;
            pending_dir_next = DIR_UP;
            dir_next         = DIR_UP;
            head_x_next      = X_START;
            head_y_next      = Y_START;
            move_req_next    = 1'b0;
            overrun_next     = 1'b0;
            hit_wall_next    = 1'b0;
            stop_pend_next   = 1'b0;
        end

        running_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            period_reg      <= BASE_VEC;
            pending_dir_reg <= DIR_UP;
            dir_reg         <= DIR_UP;
            head_x_reg      <= X_START;
            head_y_reg      <= Y_START;
            move_req_reg    <= 1'b0;
            running_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
            hit_wall_reg    <= 1'b0;
            stop_pend_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            period_reg      <= period_next;
            pending_dir_reg <= pending_dir_next;
            dir_reg         <= dir_next;
            head_x_reg      <= head_x_next;
            head_y_reg      <= head_y_next;
            move_req_reg    <= move_req_next;
            running_reg     <= running_next;
            overrun_reg     <= overrun_next;
            hit_wall_reg    <= hit_wall_next;
            stop_pend_reg   <= stop_pend_next;
        end
    end

    assign bus.move_req = move_req_reg;
    assign bus.head_x   = head_x_reg;
    assign bus.head_y   = head_y_reg;
    assign bus.dir_out  = dir_reg;
    assign bus.running  = running_reg;
    assign bus.overrun  = overrun_reg;
    assign bus.hit_wall = hit_wall_reg;
endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler with BASE_PERIOD=8; build with WRAP_EN to exercise wrap mode.
module tb_snake_move_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_req = 0;

    always #5 clk = ~clk;

    snake_move_scheduler_if #(.X_W(8), .Y_W(7)) bus ();

    snake_move_scheduler #(
        .X_MAX(159), .Y_MAX(119), .X_W(8), .Y_W(7),
        .BASE_PERIOD(8), .X_INIT(80), .Y_INIT(60)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (!bus.move_req && n < budget) begin
            tick_clk();
            n++;
        end
    endtask

    // Expect one move 8 cycles after the previous one, then acknowledge it.
    task automatic serve(input string tag, input int exp_x, input int exp_y, input int exp_dir);
        int n;
        wait_req(40, n);
        check_val({tag, "_gap"}, cyc - last_req, 8);
        check_val({tag, "_x"}, int'(bus.head_x), exp_x);
        check_val({tag, "_y"}, int'(bus.head_y), exp_y);
        check_val({tag, "_dir"}, int'(bus.dir_out), exp_dir);
        last_req = cyc;
        bus.move_ack = 1'b1;
        tick_clk();
        bus.move_ack = 1'b0;
        check_val({tag, "_ackdrop"}, int'(bus.move_req), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.pause    = 1'b0;
        bus.speed    = 2'd0;
        bus.dir_in   = 2'd0;
        bus.move_ack = 1'b0;
        repeat (3) tick_clk();
        rst = 1'b0;
        tick_clk();

        check_val("rst_req", int'(bus.move_req), 0);
        check_val("rst_x", int'(bus.head_x), 80);
        check_val("rst_y", int'(bus.head_y), 60);
        check_val("rst_dir", int'(bus.dir_out), 0);
        check_val("rst_run", int'(bus.running), 0);
        check_val("rst_ovr", int'(bus.overrun), 0);
        check_val("rst_wall", int'(bus.hit_wall), 0);

        // Basic motion upward at period 8
        bus.start = 1'b1;
        tick_clk();
        bus.start = 1'b0;
        last_req = cyc;
        check_val("start_run", int'(bus.running), 1);
        serve("mv1", 80, 59, 0);
        serve("mv2", 80, 58, 0);
        serve("mv3", 80, 57, 0);

        // Reversal DOWN ignored while heading UP, then turn RIGHT, reversal LEFT ignored
        bus.dir_in = 2'd2;
        serve("rev1", 80, 56, 0);
        serve("rev2", 80, 55, 0);
        bus.dir_in = 2'd1;
        serve("right1", 81, 55, 1);
        bus.dir_in = 2'd3;
        serve("right2", 82, 55, 1);

        // SPEED=2 picked up at the next reload; afterwards moves every 2 cycles
        bus.dir_in = 2'd0;
        bus.speed  = 2'd2;
        serve("upfast", 82, 54, 0);
        wait_req(10, n);
        check_val("fast_gap", cyc - last_req, 2);
        check_val("fast_y", int'(bus.head_y), 53);
        check_val("pre_ovr", int'(bus.overrun), 0);

        // Hold ACK low across two ticks
        repeat (5) tick_clk();
        check_val("ovr_set", int'(bus.overrun), 1);
        check_val("ovr_req_held", int'(bus.move_req), 1);
        check_val("ovr_y_held", int'(bus.head_y), 53);
        bus.move_ack = 1'b1;
        tick_clk();
        check_val("acktick_req", int'(bus.move_req), 1);
        check_val("acktick_y", int'(bus.head_y), 52);
        tick_clk();
        bus.move_ack = 1'b0;
        check_val("acktick_drop", int'(bus.move_req), 0);

        // Run LEFT at one move per cycle until the left edge
        bus.speed  = 2'd3;
        bus.dir_in = 2'd3;
        wait_req(10, n);
        check_val("left_start_y", int'(bus.head_y), 51);
        bus.move_ack = 1'b1;
        n = 0;
        while (int'(bus.head_x) != 0 && n < 200) begin
            tick_clk();
            n++;
        end
        bus.move_ack = 1'b0;
        check_val("steps_to_x0", n, 82);
        check_val("x0_dir", int'(bus.dir_out), 3);
        tick_clk();
        bus.move_ack = 1'b1;
        tick_clk();
        bus.move_ack = 1'b0;
`ifdef WRAP_EN
        check_val("wrap_x", int'(bus.head_x), 159);
        check_val("wrap_req", int'(bus.move_req), 1);
        check_val("wrap_wall", int'(bus.hit_wall), 0);
        check_val("wrap_run", int'(bus.running), 1);
`else
        check_val("wall_set", int'(bus.hit_wall), 1);
        check_val("wall_run", int'(bus.running), 0);
        check_val("wall_req", int'(bus.move_req), 0);
        check_val("wall_x", int'(bus.head_x), 0);
        seen = 0;
        repeat (10) begin
            tick_clk();
            if (bus.move_req) seen = 1;
        end
        check_val("wall_no_req", seen, 0);
`endif
        check_val("ovr_sticky", int'(bus.overrun), 1);

        // START clears sticky flags and reloads the head
        bus.speed  = 2'd0;
        bus.dir_in = 2'd0;
        bus.start  = 1'b1;
        tick_clk();
        bus.start = 1'b0;
        last_req = cyc;
        check_val("restart_ovr", int'(bus.overrun), 0);
        check_val("restart_wall", int'(bus.hit_wall), 0);
        check_val("restart_x", int'(bus.head_x), 80);
        check_val("restart_y", int'(bus.head_y), 60);
        check_val("restart_req", int'(bus.move_req), 0);
        wait_req(40, n);
        check_val("restart_gap", cyc - last_req, 8);
        check_val("restart_mv_y", int'(bus.head_y), 59);

        // Asynchronous reset between clock edges while a request is pending
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_req", int'(bus.move_req), 0);
        check_val("arst_x", int'(bus.head_x), 80);
        check_val("arst_y", int'(bus.head_y), 60);
        check_val("arst_run", int'(bus.running), 0);
        tick_clk();
        rst = 1'b0;
        tick_clk();

        // PAUSE freezes the count mid-period
        bus.start = 1'b1;
        tick_clk();
        bus.start = 1'b0;
        repeat (3) tick_clk();
        bus.pause = 1'b1;
        seen = 0;
        repeat (30) begin
            tick_clk();
            if (bus.move_req) seen = 1;
        end
        bus.pause = 1'b0;
        check_val("pause_no_req", seen, 0);
        wait_req(40, n);
        check_val("pause_resume_gap", n, 5);
        check_val("pause_mv_y", int'(bus.head_y), 59);

        // STOP during REQ is held until ACK
        bus.stop = 1'b1;
        tick_clk();
        bus.stop = 1'b0;
        check_val("stopreq_req", int'(bus.move_req), 1);
        check_val("stopreq_run", int'(bus.running), 1);
        bus.move_ack = 1'b1;
        tick_clk();
        bus.move_ack = 1'b0;
        check_val("stopack_req", int'(bus.move_req), 0);
        check_val("stopack_run", int'(bus.running), 0);

        // START and STOP together: START wins; then STOP in RUN
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick_clk();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_val("startstop_run", int'(bus.running), 1);
        tick_clk();
        bus.stop = 1'b1;
        tick_clk();
        bus.stop = 1'b0;
        check_val("stoprun_run", int'(bus.running), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
